// File: rtl/card_dealer.sv
// card_dealer: UNO draw/discard pile manager. Builds the 108-card deck,
// shuffles it with an LFSR-driven Fisher-Yates pass, deals one card per
// request and recycles the discard pile once the draw pile runs dry.
module card_dealer #(
    parameter logic [6:0] SEED    = 7'h5A,
    parameter int         N_CARDS = 108
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_req,
    input  logic       i_discard,
    input  logic [5:0] i_discard_card,
    output logic [5:0] o_card,
    output logic       o_drawn,
    output logic       o_ready,
    output logic [6:0] o_deck_cnt,
    output logic [6:0] o_disc_cnt,
    output logic       o_exhausted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHUFFLE,
        S_READY,
        S_RECYCLE
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [5:0] deck [0:N_CARDS-1];
    logic [6:0] lfsr;
    logic [6:0] idx;
    logic [6:0] deck_cnt;
    logic [6:0] disc_cnt;
    logic [5:0] latched;
    logic       pending_req;

    logic       ready;
    logic       req_ok;
    logic       disc_ok;
    logic       recycle_go;
    logic [6:0] top_idx;
    logic [6:0] newest_idx;
    logic [6:0] disc_idx;
    logic [6:0] rec_n;
    logic [6:0] rec_src;
    logic [1:0] fill_color;
    logic [4:0] fill_off;
    logic [3:0] fill_value;
    logic [5:0] fill_card;

    // Requests are refused on the cycle a card is being delivered so that
    // o_drawn can never pulse twice in a row.
    assign ready      = (state == S_READY) && !o_drawn;
    assign req_ok     = ready && i_req;
    assign disc_ok    = ready && i_discard &&
                        (({1'b0, deck_cnt} + {1'b0, disc_cnt}) != 8'd108);
    assign recycle_go = req_ok && !i_start && (deck_cnt == 7'd0) && (disc_cnt >= 7'd2);
    assign top_idx    = deck_cnt - 7'd1;
    assign newest_idx = 7'd108 - disc_cnt;
    assign disc_idx   = 7'd107 - disc_cnt;
    assign rec_n      = disc_cnt - 7'd1;
    assign rec_src    = 7'd109 - disc_cnt + idx;

    assign o_ready    = ready;
    assign o_deck_cnt = deck_cnt;
    assign o_disc_cnt = disc_cnt;

    // Canonical card for fill slot idx: 25 slots per color, then 4 wilds and 4 wild draw-fours.
    always_comb begin
        fill_color = 2'd0;
        fill_off   = 5'(idx);
        if (idx >= 7'd75) begin
            fill_color = 2'd3;
            fill_off   = 5'(idx - 7'd75);
        end else if (idx >= 7'd50) begin
            fill_color = 2'd2;
            fill_off   = 5'(idx - 7'd50);
        end else if (idx >= 7'd25) begin
            fill_color = 2'd1;
            fill_off   = 5'(idx - 7'd25);
        end
        fill_value = fill_off[4:1] + {3'b000, fill_off[0]};
        fill_card  = {fill_color, fill_value};
        if (idx >= 7'd104) begin
            fill_card = 6'h0E;
        end else if (idx >= 7'd100) begin
            fill_card = 6'h0D;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (i_start) next_state = S_FILL;
            S_FILL:    if (idx == 7'd107) next_state = S_SHUFFLE;
            S_SHUFFLE: if (deck_cnt <= 7'd1 || idx == 7'd0) next_state = S_READY;
            S_READY: begin
                if (i_start) begin
                    next_state = S_FILL;
                end else if (recycle_go) begin
                    next_state = S_RECYCLE;
                end
            end
            S_RECYCLE: if (idx == rec_n) next_state = S_SHUFFLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Deck storage, counters, free-running LFSR and the dealt-card outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < N_CARDS; j++) begin
                deck[j] <= 6'h3F;
            end
            lfsr        <= SEED;
            idx         <= 7'd0;
            deck_cnt    <= 7'd0;
            disc_cnt    <= 7'd0;
            latched     <= 6'h3F;
            pending_req <= 1'b0;
            o_card      <= 6'h3F;
            o_drawn     <= 1'b0;
            o_exhausted <= 1'b0;
        end else begin
            lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            o_drawn <= 1'b0;
            o_card  <= 6'h3F;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        idx         <= 7'd0;
                        deck_cnt    <= 7'd0;
                        disc_cnt    <= 7'd0;
                        pending_req <= 1'b0;
                        o_exhausted <= 1'b0;
                    end
                end
                S_FILL: begin
                    deck[idx] <= fill_card;
                    idx       <= idx + 7'd1;
                    if (idx == 7'd107) begin
                        deck_cnt <= 7'd108;
                        disc_cnt <= 7'd0;
                        idx      <= 7'd107;
                    end
                end
                S_SHUFFLE: begin
                    if (deck_cnt <= 7'd1 || idx == 7'd0) begin
                        if (pending_req && deck_cnt != 7'd0) begin
                            o_drawn       <= 1'b1;
                            o_card        <= deck[top_idx];
                            deck[top_idx] <= 6'h3F;
                            deck_cnt      <= deck_cnt - 7'd1;
                            o_exhausted   <= 1'b0;
                        end
                        pending_req <= 1'b0;
                    end else if (lfsr <= idx) begin
                        deck[idx]  <= deck[lfsr];
                        deck[lfsr] <= deck[idx];
                        idx        <= idx - 7'd1;
                    end
                end
                S_READY: begin
                    if (i_start) begin
                        idx         <= 7'd0;
                        deck_cnt    <= 7'd0;
                        disc_cnt    <= 7'd0;
                        pending_req <= 1'b0;
                        o_exhausted <= 1'b0;
                    end else begin
                        if (req_ok) begin
                            if (deck_cnt != 7'd0) begin
                                o_drawn       <= 1'b1;
                                o_card        <= deck[top_idx];
                                deck[top_idx] <= 6'h3F;
                                deck_cnt      <= deck_cnt - 7'd1;
                                o_exhausted   <= 1'b0;
                            end else if (disc_cnt >= 7'd2) begin
                                pending_req <= 1'b1;
                                idx         <= 7'd0;
                                o_exhausted <= 1'b0;
                                if (disc_ok) begin
                                    latched <= i_discard_card;
                                end else begin
                                    latched          <= deck[newest_idx];
                                    deck[newest_idx] <= 6'h3F;
                                end
                            end else begin
                                o_exhausted <= 1'b1;
                            end
                        end
                        if (disc_ok) begin
                            disc_cnt <= disc_cnt + 7'd1;
                            if (!recycle_go) begin
                                deck[disc_idx] <= i_discard_card;
                            end
                        end
                    end
                end
                S_RECYCLE: begin
                    if (idx != rec_n) begin
                        deck[idx]     <= deck[rec_src];
                        deck[rec_src] <= 6'h3F;
                        idx           <= idx + 7'd1;
                    end else begin
                        deck[107] <= latched;
                        disc_cnt  <= 7'd1;
                        deck_cnt  <= rec_n;
                        idx       <= rec_n - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized self-checking bench for card_dealer, with a
// multiset model of the draw pile and a list model of the discard pile.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_req = 1'b0;
    logic       i_discard = 1'b0;
    logic [5:0] i_discard_card = 6'h00;
    logic [5:0] o_card;
    logic       o_drawn;
    logic       o_ready;
    logic [6:0] o_deck_cnt;
    logic [6:0] o_disc_cnt;
    logic       o_exhausted;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         pile [64];
    logic [5:0] canon [108];
    logic [5:0] disc_q [$];
    logic       prev_drawn = 1'b0;

    card_dealer #(.SEED(7'h5A)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_req(i_req),
        .i_discard(i_discard), .i_discard_card(i_discard_card),
        .o_card(o_card), .o_drawn(o_drawn), .o_ready(o_ready),
        .o_deck_cnt(o_deck_cnt), .o_disc_cnt(o_disc_cnt), .o_exhausted(o_exhausted)
    );

    always #5 clk = ~clk;

    function automatic logic card_legal(input logic [5:0] c);
        return (c[3:0] <= 4'd12) || ((c[3:0] == 4'd13 || c[3:0] == 4'd14) && c[5:4] == 2'd0);
    endfunction

    function automatic logic [5:0] rand_card();
        int v;
        v = $urandom_range(0, 14);
        if (v >= 13) return {2'b00, 4'(v)};
        return {2'($urandom_range(0, 3)), 4'(v)};
    endfunction

    // Every dealt card must be a legal card and pulses must never be back-to-back.
    always @(negedge clk) begin
        if (o_drawn) begin
            tests_run++;
            if (prev_drawn || !card_legal(o_card)) begin
                tests_failed++;
                $display("[TB] FAIL drawn_pulse card=%h prev_drawn=%0b (need legal card, isolated pulse)", o_card, prev_drawn);
            end
        end
        prev_drawn = o_drawn;
    end

    task automatic build_canon();
        int n;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            canon[n] = {2'(c), 4'd0};
            n++;
            for (int v = 1; v <= 12; v++) begin
                for (int r = 0; r < 2; r++) begin
                    canon[n] = {2'(c), 4'(v)};
                    n++;
                end
            end
        end
        for (int r = 0; r < 4; r++) begin canon[n] = 6'h0D; n++; end
        for (int r = 0; r < 4; r++) begin canon[n] = 6'h0E; n++; end
    endtask

    task automatic pile_canonical();
        for (int i = 0; i < 64; i++) pile[i] = 0;
        for (int i = 0; i < 108; i++) pile[canon[i]]++;
    endtask

    task automatic wait_ready(input int bound, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (o_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Waits for o_ready, then issues one request (optionally with a discard).
    task automatic ready_req(input logic with_disc, input logic [5:0] dcard, input int bound,
                             output logic ok, output logic got, output logic [5:0] card);
        got  = 1'b0;
        card = 6'h3F;
        wait_ready(50, ok);
        if (!ok) return;
        i_req = 1'b1;
        i_discard = with_disc;
        i_discard_card = dcard;
        @(negedge clk);
        i_req = 1'b0;
        i_discard = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (o_drawn) begin got = 1'b1; card = o_card; break; end
            @(negedge clk);
        end
    endtask

    task automatic ready_discard(input logic [5:0] dcard, output logic ok);
        wait_ready(50, ok);
        if (!ok) return;
        i_discard = 1'b1;
        i_discard_card = dcard;
        @(negedge clk);
        i_discard = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_card, o_drawn, o_ready, o_deck_cnt, o_disc_cnt, o_exhausted} !== {6'h3F, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs card=%h drawn=%0b ready=%0b deck=%0d disc=%0d exh=%0b", o_card, o_drawn, o_ready, o_deck_cnt, o_disc_cnt, o_exhausted);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b0 || o_deck_cnt !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset ready=%0b deck=%0d (need 0/0)", o_ready, o_deck_cnt);
        end
    endtask

    task automatic test_fill();
        logic seen, ok;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (o_deck_cnt == 7'd108) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL fill_done deck=%0d (need 108 within 300 cycles)", o_deck_cnt);
        end else begin
            for (int i = 0; i < 108; i++) begin
                tests_run++;
                if (dut.deck[i] !== canon[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_slot[%0d] got=%h need=%h", i, dut.deck[i], canon[i]);
                end
            end
        end
        tests_run++;
        if (o_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ready_in_shuffle got=%0b need=0", o_ready);
        end
        wait_ready(20000, ok);
        tests_run++;
        if (!ok || o_deck_cnt !== 7'd108 || o_disc_cnt !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL shuffle_done ready=%0b deck=%0d disc=%0d (need 1/108/0)", ok, o_deck_cnt, o_disc_cnt);
        end
    endtask

    task automatic test_full_deal();
        logic ok, got;
        logic [5:0] card;
        int left;
        pile_canonical();
        for (int k = 0; k < 108; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ready_req(1'b0, 6'h00, 10, ok, got, card);
            tests_run++;
            if (!got || pile[card] == 0) begin
                tests_failed++;
                $display("[TB] FAIL deal[%0d] drawn=%0b card=%h (need a pulse with a card still in the pile)", k, got, card);
            end else begin
                pile[card]--;
            end
            tests_run++;
            if (o_deck_cnt !== 7'(107 - k)) begin
                tests_failed++;
                $display("[TB] FAIL deal_cnt[%0d] got=%0d need=%0d", k, o_deck_cnt, 107 - k);
            end
        end
        left = 0;
        for (int i = 0; i < 64; i++) left += pile[i];
        tests_run++;
        if (left != 0) begin
            tests_failed++;
            $display("[TB] FAIL deal_multiset cards_unseen=%0d need=0", left);
        end
        ready_req(1'b0, 6'h00, 6, ok, got, card);
        tests_run++;
        if (!ok || got || o_exhausted !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL exhausted ready=%0b drawn=%0b exh=%0b (need 1/0/1)", ok, got, o_exhausted);
        end
    endtask

    task automatic test_discards();
        logic ok, got;
        logic [5:0] card;
        logic [5:0] d [3];
        d[0] = 6'h25; d[1] = 6'h13; d[2] = 6'h31;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        pulse_start();
        wait_ready(20000, ok);
        pile_canonical();
        disc_q.delete();
        for (int k = 0; k < 7; k++) begin
            ready_req(1'b0, 6'h00, 10, ok, got, card);
            tests_run++;
            if (!got || pile[card] == 0) begin
                tests_failed++;
                $display("[TB] FAIL draw7[%0d] drawn=%0b card=%h", k, got, card);
            end else begin
                pile[card]--;
            end
        end
        for (int k = 0; k < 3; k++) begin
            ready_discard(d[k], ok);
            disc_q.push_back(d[k]);
        end
        tests_run++;
        if (o_disc_cnt !== 7'd3 || o_deck_cnt !== 7'd101) begin
            tests_failed++;
            $display("[TB] FAIL discard_cnts disc=%0d deck=%0d (need 3/101)", o_disc_cnt, o_deck_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (dut.deck[107 - k] !== d[k]) begin
                tests_failed++;
                $display("[TB] FAIL discard_slot[%0d] got=%h need=%h", 107 - k, dut.deck[107 - k], d[k]);
            end
        end
    endtask

    task automatic test_recycle();
        logic ok, got;
        logic [5:0] card;
        int rec [64];
        int left;
        for (int k = 0; k < 101; k++) begin
            ready_req(1'b0, 6'h00, 10, ok, got, card);
            tests_run++;
            if (!got || pile[card] == 0) begin
                tests_failed++;
                $display("[TB] FAIL drain[%0d] drawn=%0b card=%h", k, got, card);
            end else begin
                pile[card]--;
            end
        end
        for (int k = 0; k < 17; k++) begin
            card = rand_card();
            ready_discard(card, ok);
            disc_q.push_back(card);
        end
        tests_run++;
        if (o_disc_cnt !== 7'd20 || o_deck_cnt !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL pre_recycle disc=%0d deck=%0d (need 20/0)", o_disc_cnt, o_deck_cnt);
        end
        for (int i = 0; i < 64; i++) rec[i] = 0;
        for (int i = 0; i < disc_q.size() - 1; i++) rec[disc_q[i]]++;
        ready_req(1'b0, 6'h00, 20000, ok, got, card);
        tests_run++;
        if (!got || rec[card] == 0) begin
            tests_failed++;
            $display("[TB] FAIL recycle_deal drawn=%0b card=%h (need a recycled discard)", got, card);
        end else begin
            rec[card]--;
        end
        tests_run++;
        if (o_disc_cnt !== 7'd1 || o_deck_cnt !== 7'd18 || dut.deck[107] !== disc_q[disc_q.size() - 1]) begin
            tests_failed++;
            $display("[TB] FAIL recycle_state disc=%0d deck=%0d top_disc=%h (need 1/18/%h)", o_disc_cnt, o_deck_cnt, dut.deck[107], disc_q[disc_q.size() - 1]);
        end
        for (int k = 0; k < 18; k++) begin
            ready_req(1'b0, 6'h00, 10, ok, got, card);
            tests_run++;
            if (!got || rec[card] == 0) begin
                tests_failed++;
                $display("[TB] FAIL recycled_draw[%0d] drawn=%0b card=%h", k, got, card);
            end else begin
                rec[card]--;
            end
        end
        left = 0;
        for (int i = 0; i < 64; i++) left += rec[i];
        tests_run++;
        if (left != 0) begin
            tests_failed++;
            $display("[TB] FAIL recycle_multiset unseen=%0d need=0", left);
        end
        ready_req(1'b0, 6'h00, 6, ok, got, card);
        tests_run++;
        if (got || o_exhausted !== 1'b1 || o_disc_cnt !== 7'd1) begin
            tests_failed++;
            $display("[TB] FAIL one_discard_exhausted drawn=%0b exh=%0b disc=%0d (need 0/1/1)", got, o_exhausted, o_disc_cnt);
        end
    endtask

    task automatic test_same_cycle();
        logic ok, got, acc;
        logic [5:0] card, dcard;
        int dk, dc;
        pulse_start();
        wait_ready(20000, ok);
        pile_canonical();
        dk = 108;
        dc = 0;
        for (int k = 0; k < 6; k++) begin
            dcard = rand_card();
            acc = (dk + dc != 108);
            if (k == 0) begin
                ready_req(1'b0, 6'h00, 10, ok, got, card);
                acc = 1'b0;
            end else if (k < 4) begin
                ready_req(1'b1, dcard, 10, ok, got, card);
            end else begin
                ready_discard(dcard, ok);
                got = 1'b0;
            end
            if (k < 4) begin
                tests_run++;
                if (!got || pile[card] == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL same_cycle_deal[%0d] drawn=%0b card=%h", k, got, card);
                end else begin
                    pile[card]--;
                end
                dk--;
            end
            if (acc) begin
                tests_run++;
                if (dut.deck[107 - dc] !== dcard) begin
                    tests_failed++;
                    $display("[TB] FAIL same_cycle_slot[%0d] got=%h need=%h", 107 - dc, dut.deck[107 - dc], dcard);
                end
                dc++;
            end
            tests_run++;
            if (o_deck_cnt !== 7'(dk) || o_disc_cnt !== 7'(dc)) begin
                tests_failed++;
                $display("[TB] FAIL same_cycle_cnt[%0d] deck=%0d disc=%0d need=%0d/%0d", k, o_deck_cnt, o_disc_cnt, dk, dc);
            end
        end
    endtask

    task automatic test_reset_mid_shuffle();
        logic ok, seen_ready;
        pulse_start();
        for (int c = 0; c < 300; c++) begin
            if (o_deck_cnt == 7'd108) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_card, o_drawn, o_ready, o_deck_cnt, o_disc_cnt, o_exhausted} !== {6'h3F, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0} || dut.deck[0] !== 6'h3F) begin
            tests_failed++;
            $display("[TB] FAIL mid_shuffle_reset card=%h drawn=%0b ready=%0b deck=%0d disc=%0d exh=%0b slot0=%h", o_card, o_drawn, o_ready, o_deck_cnt, o_disc_cnt, o_exhausted, dut.deck[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_ready = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (o_ready) seen_ready = 1'b1;
        end
        tests_run++;
        if (seen_ready) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_reset got=1 need=0 until restart");
        end
        pulse_start();
        wait_ready(20000, ok);
        tests_run++;
        if (!ok || o_deck_cnt !== 7'd108) begin
            tests_failed++;
            $display("[TB] FAIL restart_after_reset ready=%0b deck=%0d (need 1/108)", ok, o_deck_cnt);
        end
    endtask

    initial begin
        build_canon();
        test_reset();
        test_fill();
        test_full_deal();
        test_discards();
        test_recycle();
        test_same_cycle();
        test_reset_mid_shuffle();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Draw pile and discard pile manager for the UNO game; sits directly upstream of each player's hand block.
- Builds the 108-card deck and shuffles it with an LFSR-driven Fisher-Yates pass.
- Deals one card per request, using the same pulse-plus-card handshake the hand block consumes (o_drawn / o_card).
- Collects discards and reshuffles them into a new draw pile when the draw pile runs dry.

Parameters:
- SEED, 7'h5A, initial LFSR value; must be non-zero.
- N_CARDS, 108, deck size; fixed, not intended for override.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: asynchronous, active-low.
- i_start  in  1  pulse; build and shuffle a fresh deck (valid in S_IDLE or S_READY).
- i_req  in  1  pulse; request one card.
- i_discard  in  1  pulse; push i_discard_card onto the discard pile.
- i_discard_card  in  6  played card, {color[1:0], value[3:0]}.
- o_card  out  6  dealt card; valid only while o_drawn=1.
- o_drawn  out  1  one-cycle pulse, card delivered.
- o_ready  out  1  high only in S_READY; i_req/i_discard accepted only then.
- o_deck_cnt  out  7  cards left in the draw pile.
- o_disc_cnt  out  7  cards in the discard pile.
- o_exhausted  out  1  draw pile empty and o_disc_cnt<=1 (request cannot be served).

Behaviour:
- Card encoding:
  - Colors 0..3 = red, yellow, green, blue.
  - Values 0-9 numeric; 10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild draw-four.
  - Wild cards carry color 2'b00.
  - 6'h3F = empty slot.
- Storage: deck[0:107] register array.
  - Draw pile occupies [0, deck_cnt); the top card is deck[deck_cnt-1].
  - Discard pile grows downward from 107: the k-th discard goes to deck[107-k]; the newest is at deck[108-disc_cnt].
- LFSR: 7-bit, taps x^7+x^6+1, advances every cycle in every state (free-running) so that the timing of i_start adds entropy.
- Reset (async):
  - state=S_IDLE; all deck slots = 6'h3F.
  - deck_cnt=0, disc_cnt=0, lfsr=SEED.
  - o_card=6'h3F; o_drawn=0, o_ready=0, o_exhausted=0.
  - Reset mid-fill, mid-shuffle or mid-recycle aborts the operation with no partial output.
- S_IDLE: on i_start -> S_FILL with idx=0.
- S_FILL: 108 cycles, one slot per cycle, canonical order:
  - Per color c, 25 slots at base c*25: value 0 once, then values 1..12 twice each, ascending.
  - Slots 100-103 = 6'h0D; slots 104-107 = 6'h0E.
  - Then deck_cnt=108, disc_cnt=0, i=107 -> S_SHUFFLE.
- S_SHUFFLE (range [0, deck_cnt)):
  - Each cycle, r = lfsr.
  - If r <= i: swap deck[i] and deck[r], then i--. Otherwise hold i (rejection sampling).
  - Exit to S_READY when i==0, or immediately if deck_cnt<=1.
- S_READY (o_ready=1):
  - i_req with deck_cnt>0: next cycle o_drawn=1, o_card=deck[deck_cnt-1], that slot := 3F, deck_cnt--.
  - i_req with deck_cnt==0 and disc_cnt>=2: enter S_RECYCLE, then deliver the card after the reshuffle.
  - i_req with deck_cnt==0 and disc_cnt<=1: request dropped, o_exhausted=1, no o_drawn.
  - i_discard: deck[107-disc_cnt] := card; disc_cnt++. Ignored if deck_cnt+disc_cnt==108.
  - i_req and i_discard in the same cycle: both served; the discard write uses the pre-cycle counts.
  - i_start: refill from scratch (S_FILL); pending piles are discarded.
- Requests and discards are not accepted outside S_READY (o_ready=0); they are not queued.
- S_RECYCLE:
  - Latch the newest discard in a register; n = disc_cnt-1.
  - For k=0..n-1, one per cycle: deck[k] := deck[109-disc_cnt+k].
  - Ascending copy is safe: the source index is always greater than the destination, so no unread source is overwritten.
  - Then clear the vacated slots, deck[107] := latched card, disc_cnt=1, deck_cnt=n, i=n-1 -> S_SHUFFLE.
  - After the shuffle, the pending request is served automatically with a pending_req flag: o_drawn fires on the first S_READY cycle.
- Width rules:
  - Counters are 7-bit and saturate logically; deck_cnt+disc_cnt never exceeds 108.
  - Indices are computed at 7 bits.
- o_drawn is never high in two consecutive cycles.

Test Plan:
- Reset, i_start, inspect after fill (pre-shuffle tap, SEED forced): deck[0]=6'h00, deck[1]=deck[2]=6'h01, deck[25]=6'h10, deck[100]=6'h0D, deck[107]=6'h0E.
- Full shuffle then 108 back-to-back requests, one per o_ready -> exactly 108 o_drawn pulses, multiset matches the canonical deck, o_deck_cnt reaches 0, 109th request -> o_exhausted=1, no pulse.
- Draw 7 cards, discard 6'h25, 6'h13, 6'h31 -> o_disc_cnt=3, o_deck_cnt=101, discard slots 107/106/105 hold 25/13/31.
- Drain the pile with 20 discards pending, then i_req -> S_RECYCLE; o_drawn follows, o_disc_cnt=1 holding the last discard, o_deck_cnt=18, no 6'h3F ever dealt.
- Same-cycle i_req and i_discard in S_READY -> one card dealt and the discard stored; counts change by -1 and +1.
- Assert i_rst_n=0 midway through S_SHUFFLE -> all outputs at reset values immediately, o_ready=0 until the next i_start completes.
